// File: rtl/button_arbiter.sv
// button_arbiter: latches conditioned button presses as pending requests and
// issues them one at a time over a valid/ready handshake, round-robin.
// Optional macro AUTO_REPEAT_EN: adds per-button hold counters that generate
// repeat requests while a button level stays high.
module button_arbiter #(
   parameter int N_BTN        = 4,
   parameter int ID_W         = 2,
   parameter int REPEAT_DELAY = 50000000,
   parameter int REPEAT_RATE  = 10000000,
   parameter int CNT_W        = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_pulse,
   input  logic [N_BTN-1:0] btn_level,
   output logic             cmd_valid,
   output logic [ID_W-1:0]  cmd_id,
   output logic [N_BTN-1:0] cmd_onehot,
   input  logic             cmd_ready,
   output logic [N_BTN-1:0] pending,
   output logic             overflow
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_OFFER = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [N_BTN-1:0] r_pending;
   logic [N_BTN-1:0] w_pending_next;
   logic             r_cmd_valid;
   logic             w_valid_next;
   logic [ID_W-1:0]  r_cmd_id;
   logic [ID_W-1:0]  w_id_next;
   logic [N_BTN-1:0] r_cmd_onehot;
   logic [N_BTN-1:0] w_onehot_next;
   logic [ID_W-1:0]  r_ptr;
   logic [ID_W-1:0]  w_ptr_next;
   logic             r_overflow;
   logic             w_overflow_next;

   // New requests this cycle: presses plus (optionally) repeat ticks
   logic [N_BTN-1:0] w_req;

   // Round-robin search results
   logic             w_hi_found;
   logic [ID_W-1:0]  w_hi_id;
   logic             w_lo_found;
   logic [ID_W-1:0]  w_lo_id;
   logic             w_sel_any;
   logic [ID_W-1:0]  w_sel_id;
   logic [N_BTN-1:0] w_sel_onehot;
   logic [N_BTN-1:0] w_clear;
   logic [ID_W:0]    w_id_inc;
   logic [ID_W-1:0]  w_id_wrap;

`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] L_DELAY  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] L_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

   logic [N_BTN-1:0] w_tick;

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_repeat
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_inc;

      assign w_cnt_inc  = r_cnt + CNT_W'(1);
      // Tick on the held cycle whose count reaches the delay; reload so the
      // next tick lands one repeat period later.
      assign w_tick[gi] = btn_level[gi] && (w_cnt_inc == L_DELAY);

      // Hold counter: counts held cycles, clears on release
      always_ff @(posedge clk) begin
         if (rst || !btn_level[gi]) begin
            r_cnt <= '0;
         end else if (w_tick[gi]) begin
            r_cnt <= L_RELOAD;
         end else begin
            r_cnt <= w_cnt_inc;
         end
      end
   end

   assign w_req = btn_pulse | w_tick;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (^btn_level) ^ (REPEAT_DELAY > REPEAT_RATE) ^ (CNT_W > 0);
   assign w_req        = btn_pulse;
`endif

   // Round-robin pick: lowest pending index at or above ptr, else lowest overall
   always_comb begin
      w_hi_found = 1'b0;
      w_hi_id    = '0;
      w_lo_found = 1'b0;
      w_lo_id    = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_lo_found = 1'b1;
            w_lo_id    = ID_W'(i);
            if (ID_W'(i) >= r_ptr) begin
               w_hi_found = 1'b1;
               w_hi_id    = ID_W'(i);
            end
         end
      end
      w_sel_any    = w_lo_found;
      w_sel_id     = w_hi_found ? w_hi_id : w_lo_id;
      w_sel_onehot = N_BTN'(1) << w_sel_id;
   end

   // Pointer advance past the accepted id, wrapping at N_BTN
   always_comb begin
      w_id_inc  = {1'b0, r_cmd_id} + (ID_W+1)'(1);
      w_id_wrap = (w_id_inc >= (ID_W+1)'(N_BTN)) ? '0 : w_id_inc[ID_W-1:0];
   end

   // Next-state and datapath: IDLE grants, OFFER waits for the handshake
   always_comb begin
      w_state_next  = r_state;
      w_valid_next  = r_cmd_valid;
      w_id_next     = r_cmd_id;
      w_onehot_next = r_cmd_onehot;
      w_ptr_next    = r_ptr;
      w_clear       = '0;
      case (r_state)
         S_IDLE: begin
            if (w_sel_any) begin
               w_clear       = w_sel_onehot;
               w_id_next     = w_sel_id;
               w_onehot_next = w_sel_onehot;
               w_valid_next  = 1'b1;
               w_state_next  = S_OFFER;
            end
         end
         S_OFFER: begin
            if (cmd_ready) begin
               w_valid_next  = 1'b0;
               w_onehot_next = '0;
               w_ptr_next    = w_id_wrap;
               w_state_next  = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      // A press on the same edge as its selection is kept (set wins)
      w_pending_next  = (r_pending & ~w_clear) | w_req;
      // Only real presses merging into an already-pending bit are flagged
      w_overflow_next = r_overflow | (|(btn_pulse & r_pending & ~w_clear));
   end

   // State and datapath registers; reset drops any offered command
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_pending    <= '0;
         r_cmd_valid  <= 1'b0;
         r_cmd_id     <= '0;
         r_cmd_onehot <= '0;
         r_ptr        <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_pending    <= w_pending_next;
         r_cmd_valid  <= w_valid_next;
         r_cmd_id     <= w_id_next;
         r_cmd_onehot <= w_onehot_next;
         r_ptr        <= w_ptr_next;
         r_overflow   <= w_overflow_next;
      end
   end

   assign cmd_valid  = r_cmd_valid;
   assign cmd_id     = r_cmd_id;
   assign cmd_onehot = r_cmd_onehot;
   assign pending    = r_pending;
   assign overflow   = r_overflow;

endmodule

// File: doc/button_arbiter.md
Name: button_arbiter

Overview:
Scheduler between the conditioned push-button chain (debounce -> sync -> edge detect) and the game/control logic.
- Collects single-cycle press pulses from N_BTN conditioned buttons.
- Latches each press as pending so no press is lost while the consumer is busy.
- Issues one command at a time over a valid/ready handshake.
- Grants are round-robin, so simultaneous presses are serviced fairly.

Parameters:
N_BTN, 4, number of button inputs (2..2^ID_W)
ID_W, 2, width of cmd_id
REPEAT_DELAY, 50000000, held-level cycles before first auto-repeat tick (AUTO_REPEAT_EN only)
REPEAT_RATE, 10000000, cycles between later auto-repeat ticks (AUTO_REPEAT_EN only); must be < REPEAT_DELAY
CNT_W, 26, repeat counter width; must satisfy 2^CNT_W > REPEAT_DELAY

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
btn_pulse  in  N_BTN  one-cycle press pulses from edge detectors, already synchronous to clk
btn_level  in  N_BTN  debounced, synced button levels (used only with AUTO_REPEAT_EN)
cmd_valid  out  1  command offered
cmd_id  out  ID_W  index of granted button
cmd_onehot  out  N_BTN  one-hot of cmd_id; all zero when cmd_valid=0
cmd_ready  in  1  consumer accepts the command when cmd_valid & cmd_ready
pending  out  N_BTN  registered pending-request vector
overflow  out  1  sticky flag: a press arrived while its pending bit was already set

Behaviour:
- Reset (rst high at an edge):
  - pending=0, cmd_valid=0, cmd_id=0, cmd_onehot=0, overflow=0.
  - Round-robin pointer ptr=0, state=IDLE, repeat counters=0.
  - Reset overrides every other event, including mid-offer; an offered command is dropped.
- Pending set/clear:
  - pending[i] sets at the edge where btn_pulse[i]=1 (or a repeat tick for i occurs).
  - pending[i] clears at the edge where i is selected.
  - Set and clear on the same edge: set wins, so the new press is kept.
- Overflow: btn_pulse[i]=1 while pending[i] is already 1 (and i is not being selected that edge) -> press merged, overflow<=1 until reset. Repeat ticks never set overflow.
- FSM states: IDLE, OFFER.
  - IDLE, pending!=0: select the first set bit searching ptr, ptr+1, ... N_BTN-1, 0, ... (wrap).
    - Register cmd_id and cmd_onehot, clear that pending bit, set cmd_valid<=1, go to OFFER.
  - IDLE, pending=0: stay; cmd_valid=0.
  - OFFER: cmd_valid, cmd_id and cmd_onehot hold stable while cmd_ready=0.
    - On cmd_valid & cmd_ready: cmd_valid<=0, cmd_onehot<=0, ptr<=(cmd_id+1) mod N_BTN, go to IDLE.
    - cmd_id keeps its last value when invalid.
- Latency: pulse sampled at edge k -> pending visible after k -> cmd_valid high after edge k+1 (two cycles).
- Throughput: at most one command per two cycles; IDLE gives one bubble after each handshake.
- btn_pulse during OFFER for the offered button: its pending bit was cleared at selection, so it is re-set and produces a second command later.

Optional Feature:
AUTO_REPEAT_EN
- Defined:
  - One CNT_W counter per button. It increments each cycle btn_level[i]=1 and clears to 0 on any cycle btn_level[i]=0.
  - When the counter reaches REPEAT_DELAY: one repeat tick for i, counter reloads to REPEAT_DELAY-REPEAT_RATE, giving a tick every REPEAT_RATE cycles while held.
  - Ticks behave exactly like btn_pulse for pending set, but never set overflow.
- Not defined: no counters are built, btn_level is ignored, REPEAT_* and CNT_W are unused, and only btn_pulse creates requests.

Test Plan:
Benches use REPEAT_DELAY=8, REPEAT_RATE=4, N_BTN=4 unless stated.
1. rst=1 for 2 cycles with random btn_pulse -> cmd_valid=0, cmd_onehot=0000, cmd_id=0, pending=0000, overflow=0 after reset.
2. Single btn_pulse=0010 at edge k, cmd_ready=1 -> cmd_valid=1 exactly one cycle after edge k+1, cmd_id=1, cmd_onehot=0010, then pending=0000.
3. btn_pulse=1111 one cycle, cmd_ready=1 -> grants in order id 0,1,2,3, each valid one cycle with one idle cycle between. Then btn_pulse=1001 -> id 0 then id 3 (ptr was 0 after wrap).
4. btn_pulse=0100, cmd_ready=0 for 10 cycles -> cmd_valid held, id=2 stable.
   - Second pulse on bit 2 during the hold -> pending=0100, overflow=0.
   - Third pulse -> overflow=1.
   - Release cmd_ready -> exactly two commands with id 2 in total.
5. cmd_valid=1 with cmd_ready=0 and pending=1010, assert rst one cycle -> next cycle cmd_valid=0, pending=0000, ptr=0; a later pulse 0010 grants id 1.
6. AUTO_REPEAT_EN defined: pulse bit 0 and hold btn_level[0]=1 for 20 cycles, cmd_ready=1 -> one command from the pulse plus repeat commands from ticks at held cycles 8, 12, 16, 20. Same stimulus with the macro undefined -> exactly one command.
